// File: rtl/instr_mem_loader_ctrl_pkg.sv
// Shared types and widths for the instruction-memory loader controller.
package instr_mem_pkg;
  localparam int INSTR_W = 32;
  localparam int MEM_AW  = 6;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    REWIND,
    RUN,
    DONE
  } ctrl_state_e;
endpackage

// File: rtl/instr_mem_loader_ctrl_if.sv
// Load stream, core fetch port and instruction-memory port of the loader controller.
interface instr_mem_loader_ctrl_if
  import instr_mem_pkg::*;
#(
  parameter int AW = 6
);
  logic               ld_start;
  logic               ld_valid;
  logic               ld_ready;
  logic [INSTR_W-1:0] ld_data;
  logic               ld_last;
  logic               ld_err;
  logic               restart;
  logic               fetch_req;
  logic               fetch_ready;
  logic               fetch_rvalid;
  logic [INSTR_W-1:0] fetch_rdata;
  logic [AW-1:0]      fetch_raddr;
  logic [AW:0]        prog_len;
  logic               busy;
  logic               prog_done;
  logic               mem_store_en;
  logic [MEM_AW-1:0]  mem_store_address;
  logic [INSTR_W-1:0] mem_store_data;
  logic               mem_next_instr;
  logic [INSTR_W-1:0] mem_instr;
  logic               mem_instr_valid;

  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last, restart, fetch_req,
           mem_instr, mem_instr_valid,
    output ld_ready, ld_err, fetch_ready, fetch_rvalid, fetch_rdata, fetch_raddr,
           prog_len, busy, prog_done, mem_store_en, mem_store_address,
           mem_store_data, mem_next_instr
  );

  modport master (
    output ld_start, ld_valid, ld_data, ld_last, restart, fetch_req,
           mem_instr, mem_instr_valid,
    input  ld_ready, ld_err, fetch_ready, fetch_rvalid, fetch_rdata, fetch_raddr,
           prog_len, busy, prog_done, mem_store_en, mem_store_address,
           mem_store_data, mem_next_instr
  );
endinterface

// File: rtl/instr_mem_loader_ctrl.sv
// Loads a program into the instruction memory, rewinds its read pointer by
// re-storing word 0, then serves core fetches through the next-instruction port.
module instr_mem_loader_ctrl
  import instr_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  instr_mem_loader_ctrl_if.slave  bus
);

  ctrl_state_e        r_state;
  ctrl_state_e        w_state_nxt;
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_raddr;
  logic [AW:0]        r_fetch_cnt;
  logic [AW:0]        r_prog_len;
  logic [INSTR_W-1:0] r_word0;
  logic               r_ld_err;

  logic               w_ld_ready;
  logic               w_fetch_ready;
  logic               w_store_en;
  logic [MEM_AW-1:0]  w_store_addr;
  logic [INSTR_W-1:0] w_store_data;
  logic               w_ld_acc;
  logic               w_fetch_acc;
  logic               w_at_end;

  assign w_at_end    = (r_wr_ptr == AW'(DEPTH - 1));
  assign w_ld_acc    = w_ld_ready & bus.ld_valid;
  assign w_fetch_acc = w_fetch_ready & bus.fetch_req;

  always_comb begin
    w_state_nxt   = r_state;
    w_ld_ready    = 1'b0;
    w_fetch_ready = 1'b0;
    w_store_en    = 1'b0;
    w_store_addr  = '0;
    w_store_data  = '0;
    case (r_state)
      IDLE: if (bus.ld_start) w_state_nxt = LOAD;
      LOAD: begin
        w_ld_ready = 1'b1;
        if (bus.ld_valid) begin
          w_store_en   = 1'b1;
          w_store_addr = MEM_AW'(r_wr_ptr);
          w_store_data = bus.ld_data;
          if (bus.ld_last || w_at_end) w_state_nxt = REWIND;
        end
      end
      // Re-storing word 0 is the only way to pull the memory read pointer back to 0.
      REWIND: begin
        w_store_en   = 1'b1;
        w_store_data = r_word0;
        w_state_nxt  = RUN;
      end
      RUN: begin
        w_fetch_ready = (r_fetch_cnt < r_prog_len) && !bus.restart;
        if (bus.restart)                    w_state_nxt = REWIND;
        else if (r_fetch_cnt == r_prog_len) w_state_nxt = DONE;
      end
      DONE: begin
        if (bus.ld_start)     w_state_nxt = LOAD;
        else if (bus.restart) w_state_nxt = REWIND;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_raddr     <= '0;
      r_fetch_cnt <= '0;
      r_prog_len  <= '0;
      r_word0     <= '0;
      r_ld_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state != LOAD && w_state_nxt == LOAD) begin
        r_wr_ptr <= '0;
        r_ld_err <= 1'b0;
      end
      if (w_ld_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (r_wr_ptr == '0) r_word0 <= bus.ld_data;
        if (bus.ld_last || w_at_end) r_prog_len <= {1'b0, r_wr_ptr} + (AW+1)'(1);
        if (w_at_end && !bus.ld_last) r_ld_err <= 1'b1;
      end
      if (r_state == REWIND) r_fetch_cnt <= '0;
      if (w_fetch_acc) begin
        r_fetch_cnt <= r_fetch_cnt + (AW+1)'(1);
        r_raddr     <= r_fetch_cnt[AW-1:0];
      end
    end
  end

  assign bus.ld_ready          = w_ld_ready;
  assign bus.ld_err            = r_ld_err;
  assign bus.fetch_ready       = w_fetch_ready;
  assign bus.fetch_rvalid      = bus.mem_instr_valid;
  assign bus.fetch_rdata       = bus.mem_instr;
  assign bus.fetch_raddr       = r_raddr;
  assign bus.prog_len          = r_prog_len;
  assign bus.busy              = (r_state == LOAD) || (r_state == REWIND);
  assign bus.prog_done         = (r_state == DONE);
  assign bus.mem_store_en      = w_store_en;
  assign bus.mem_store_address = w_store_addr;
  assign bus.mem_store_data    = w_store_data;
  assign bus.mem_next_instr    = w_fetch_acc;

endmodule
